// File: rtl/nsa_pkg.sv
// nsa_pkg: shared definitions for the nibble-serial adder.
// - SLICE          bits handled per iteration (fixed by cla_slice4)
// - WIDTH_DEFAULT  default operand width of nibble_serial_adder32
// - state_e        FSM state encoding (2-bit; encoding 3 is unused/illegal)
package nsa_pkg;

  localparam int SLICE         = 4;
  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_slice4.sv
// cla_slice4: combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  4  addend nibbles
//   ci    in  1  carry in
//   s     out 4  sum nibble
//   co    out 1  carry out of bit 3
//   c3    out 1  carry into bit 3 (used for signed overflow on the top nibble)
module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  // p uses OR (carry-propagate in the lookahead sense); the sum itself needs XOR.
  assign g = a & b;
  assign p = a | b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = a ^ b ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder32.sv
// nibble_serial_adder32: multi-cycle add/sub that reuses one cla_slice4 over
// WIDTH/4 cycles. Operands are latched on accept, so the producer may change
// them freely once in_ready has dropped.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, sub, c_in)
//   out_valid / out_ready result handshake (sum, c_out, ovf, zero)
//   sub = 1 computes a + ~b + 1 and ignores c_in
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand bundle
// RUN   | one nibble per cycle, cnt selects the nibble
// DONE  | out_valid=1, result held until out_ready
module nibble_serial_adder32
  import nsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             c_out_q,     c_out_d;
  logic             ovf_q,       ovf_d;
  logic             zero_q,      zero_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_s;
  logic             slice_co;
  logic             slice_c3;

  assign slice_a = a_q[int'(cnt_q) * SLICE +: SLICE];
  assign slice_b = b_q[int'(cnt_q) * SLICE +: SLICE];

  cla_slice4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          // Clear the previous result so nothing stale lingers during RUN.
          sum_d   = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q) * SLICE +: SLICE] = slice_s;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          c_out_d = slice_co;
          ovf_d   = slice_c3 ^ slice_co;
          // sum_d already holds the final nibble here.
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder32.sv
// Self-checking bench for nibble_serial_adder32: directed vector table,
// reset / back-pressure sequences, and a randomized handshake run.
module tb_nibble_serial_adder32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        ovf;
  logic        zero;

  int n_cmp;
  int n_bad;

  nibble_serial_adder32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        c_in;
    logic [31:0] exp_sum;
    logic        exp_co;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  vec_t vecs[12];
  res_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic msub, input logic mcin);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] t;
    bb   = msub ? ~mb : mb;
    t    = {1'b0, ma} + {1'b0, bb} + {32'd0, (msub ? 1'b1 : mcin)};
    r.s  = t[31:0];
    r.co = t[32];
    r.ov = (ma[31] == bb[31]) && (t[31] != ma[31]);
    r.z  = (t[31:0] == 32'd0);
    return r;
  endfunction

  // Waits for in_ready, presents the bundle, returns just after the accept edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic isub, input logic icin);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("issue_in_ready_timeout", 64'd0, 64'd1);
    a = ia; b = ib; sub = isub; c_in = icin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    // Scramble inputs: the unit must use its latched copies.
    a = ~ia; b = ~ib; sub = ~isub; c_in = ~icin;
  endtask

  // Counts edges from the accept edge until out_valid; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    int   bad;
    int   seen;
    logic [31:0] hold_s;
    logic [2:0]  hold_f;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", {28'd0, c_out, ovf, zero, sum}, 64'd0);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].c_in);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
      check($sformatf("v%0d_sum", i), 64'(sum), 64'(vecs[i].exp_sum));
      check($sformatf("v%0d_c_out", i), 64'(c_out), 64'(vecs[i].exp_co));
      check($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
      check($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].exp_zero));
      check($sformatf("v%0d_in_ready_busy", i), 64'(in_ready), 64'd0);
      drain();
    end

    // Reset mid-RUN
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_outputs", {28'd0, c_out, ovf, zero, sum}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrun_rst_no_result", 64'(seen), 64'd0);
    issue(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    wait_result(lat);
    check("post_rst_latency", 64'(lat), 64'd8);
    check("post_rst_sum", 64'(sum), 64'd7);
    drain();

    // Reset while DONE holds a nonzero result
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    wait_result(lat);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("done_rst_sum", 64'(sum), 64'd0);
    check("done_rst_out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: 20 stalled cycles, with a new bundle waiting
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_result(lat);
    hold_s = sum; hold_f = {c_out, ovf, zero};
    check("bp_sum", 64'(hold_s), 64'h8000_0000);
    a = 32'h1; b = 32'h1; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sum !== hold_s || {c_out, ovf, zero} !== hold_f || in_ready !== 1'b0 || out_valid !== 1'b1)
        bad++;
    end
    check("bp_stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_out_valid", 64'(out_valid), 64'd0);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h5555_5555;
    wait_result(lat);
    check("bp_next_latency", 64'(lat), 64'd8);
    check("bp_next_sum", 64'(sum), 64'd2);
    drain();

    // Random handshake run with scoreboard
    begin
      int   sent;
      int   got;
      int   cyc;
      logic acc_pending;
      res_t e;
      localparam int N_OPS = 2000;
      sent = 0; got = 0; acc_pending = 1'b0;
      for (cyc = 0; cyc < 80000 && got < N_OPS; cyc++) begin
        @(negedge clk);
        if (acc_pending) begin
          in_valid = 1'b0;
          acc_pending = 1'b0;
          a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
        end
        if (!in_valid && sent < N_OPS && $urandom_range(0, 3) != 0) begin
          a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
          if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
          if ($urandom_range(0, 7) == 0) b = a;
          in_valid = 1'b1;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, sub, c_in));
          sent++;
          acc_pending = 1'b1;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("rand_spurious_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rand_op%0d", got), {29'd0, ovf, zero, c_out, sum},
                  {29'd0, e.ov, e.z, e.co, e.s});
          end
          got++;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("rand_results_count", 64'(got), 64'(N_OPS));
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
